// File: rtl/detector_110.sv
// -----------------------------------------------------------------------------
// detector_110
//   Moore FSM that raises w for one cycle each time the serial stream on `a`
//   completes the pattern "110". Overlapping matches are allowed: the trailing
//   1 of a new pattern may follow directly after a detection.
//
//   Optional feature (macro DETECTOR_110_COUNT_EN):
//     Adds a saturating detection counter det_cnt (CNT_W bits) and a
//     synchronous clear cnt_clr. Without the macro, those ports and the
//     counter are absent and CNT_W only goes through its range check.
//
//   Reset `rst` is synchronous and active-low.
// -----------------------------------------------------------------------------
module detector_110 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
`ifdef DETECTOR_110_COUNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] det_cnt,
`endif
  output logic             w,
  output logic [1:0]       state
);

  // Reject an illegal counter width when the design is elaborated.
  if (CNT_W < 1 || CNT_W > 32) begin : g_cnt_w_check
    $error("detector_110: CNT_W must be in 1..32");
  end

  typedef enum logic [1:0] {
    RESET  = 2'b00,
    GOT1   = 2'b01,
    GOT11  = 2'b10,
    GOT110 = 2'b11
  } state_t;

  state_t state_q;
  state_t state_d;

  // State register: synchronous active-low reset, then next-state load.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking (<=) so every flop samples the
    // pre-edge values, independent of the order the blocks are evaluated.
    if (!rst) state_q <= RESET;
    else      state_q <= state_d;
  end

  // Next-state and Moore output decode.
  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no
    // latch can be inferred.
    state_d = state_q;
    w       = 1'b0;
    unique case (state_q)
      RESET:   state_d = a ? GOT1  : RESET;
      GOT1:    state_d = a ? GOT11 : RESET;
      GOT11:   state_d = a ? GOT11 : GOT110;
      GOT110: begin
        // A trailing 1 after a detection starts the next match.
        state_d = a ? GOT1 : RESET;
        w       = 1'b1;
      end
      default: state_d = RESET;
    endcase
  end

  // The debug port shows the registered state itself.
  assign state = state_q;

`ifdef DETECTOR_110_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic hit;
  assign hit = (state_d == GOT110);

  // Saturating detection counter; clear beats a simultaneous increment.
  always_ff @(posedge clk) begin
    if (!rst)                        det_cnt <= '0;
    else if (cnt_clr)                det_cnt <= '0;
    else if (hit && det_cnt != CNT_MAX) det_cnt <= det_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_detector_110.sv
// -----------------------------------------------------------------------------
// tb_detector_110
//   Table-driven bench for detector_110. Each record gives the inputs for one
//   rising edge and the state/w/det_cnt expected right after it. Expected
//   values go into a scoreboard queue as the inputs are driven and are popped
//   and compared #1 after the edge. Counter checks apply only when
//   DETECTOR_110_COUNT_EN is defined; the DUT is built with CNT_W=2 so
//   saturation is reachable.
// -----------------------------------------------------------------------------
module tb_detector_110;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             a;
  logic             w;
  logic [1:0]       state;
  logic             cnt_clr;
  logic [CNT_W-1:0] det_cnt;

  detector_110 #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
`ifdef DETECTOR_110_COUNT_EN
    .cnt_clr (cnt_clr),
    .det_cnt (det_cnt),
`endif
    .w       (w),
    .state   (state)
  );

`ifndef DETECTOR_110_COUNT_EN
  assign det_cnt = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       a;
    logic       clr;
    logic [1:0] st;
    logic       w;
    int         cnt;
    string      name;
  } vec_t;

  typedef struct {
    logic [1:0] st;
    logic       w;
    int         cnt;
    string      name;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic void add(input logic r, input logic av, input logic c,
                              input logic [1:0] st, input logic wv,
                              input int cnt, input string name);
    vec_t v;
    v.rst = r; v.a = av; v.clr = c; v.st = st; v.w = wv; v.cnt = cnt;
    v.name = name;
    tbl.push_back(v);
  endfunction

  // Drive one edge worth of inputs, queue the expectation, compare after edge.
  task automatic step(input vec_t v);
    exp_t e;
    rst     = v.rst;
    a       = v.a;
    cnt_clr = v.clr;
    e.st = v.st; e.w = v.w; e.cnt = v.cnt; e.name = v.name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check({e.name, "_state"}, int'(state), int'(e.st));
      check({e.name, "_w"}, int'(w), int'(e.w));
`ifdef DETECTOR_110_COUNT_EN
      check({e.name, "_cnt"}, int'(det_cnt), e.cnt);
`endif
    end
  endtask

  initial begin
    rst = 1'b0; a = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);

    // Reset held for two edges with a toggling and clear high.
    add(0, 1, 1, 2'b00, 0, 0, "rst0");
    add(0, 0, 0, 2'b00, 0, 0, "rst1");
    // 1,1,0 -> 01,10,11 with a single w cycle.
    add(1, 1, 0, 2'b01, 0, 0, "p110_1");
    add(1, 1, 0, 2'b10, 0, 0, "p110_2");
    add(1, 0, 0, 2'b11, 1, 1, "p110_3");
    add(1, 0, 0, 2'b00, 0, 1, "p110_4");
    // Long run of ones, then 0,0: one pulse after the fifth edge.
    add(1, 1, 0, 2'b01, 0, 1, "run_1");
    add(1, 1, 0, 2'b10, 0, 1, "run_2");
    add(1, 1, 0, 2'b10, 0, 1, "run_3");
    add(1, 1, 0, 2'b10, 0, 1, "run_4");
    add(1, 0, 0, 2'b11, 1, 2, "run_5");
    add(1, 0, 0, 2'b00, 0, 2, "run_6");
    // Back-to-back overlapping detections, three cycles apart (saturates at 3).
    add(1, 1, 0, 2'b01, 0, 2, "ovl_1");
    add(1, 1, 0, 2'b10, 0, 2, "ovl_2");
    add(1, 0, 0, 2'b11, 1, 3, "ovl_3");
    add(1, 1, 0, 2'b01, 0, 3, "ovl_4");
    add(1, 1, 0, 2'b10, 0, 3, "ovl_5");
    add(1, 0, 0, 2'b11, 1, 3, "ovl_6");
    add(1, 0, 0, 2'b00, 0, 3, "ovl_7");
    // 0,1,0,1,0 never detects.
    add(1, 0, 0, 2'b00, 0, 3, "nod_1");
    add(1, 1, 0, 2'b01, 0, 3, "nod_2");
    add(1, 0, 0, 2'b00, 0, 3, "nod_3");
    add(1, 1, 0, 2'b01, 0, 3, "nod_4");
    add(1, 0, 0, 2'b00, 0, 3, "nod_5");

    foreach (tbl[i]) step(tbl[i]);
    tbl.delete();

    // Reset mid-pattern discards progress; the following 0 must not detect.
    add(1, 1, 0, 2'b01, 0, 3, "mid_1");
    add(1, 1, 0, 2'b10, 0, 3, "mid_2");
    add(0, 1, 0, 2'b00, 0, 0, "mid_rst");
    add(1, 0, 0, 2'b00, 0, 0, "mid_0");
    // Reset while w is high drops w on the next edge.
    add(1, 1, 0, 2'b01, 0, 0, "rw_1");
    add(1, 1, 0, 2'b10, 0, 0, "rw_2");
    add(1, 0, 0, 2'b11, 1, 1, "rw_3");
    add(0, 1, 1, 2'b00, 0, 0, "rw_rst");
    // Clear mid-pattern leaves the FSM alone; then five detections saturate.
    add(1, 1, 1, 2'b01, 0, 0, "clr_fsm");
    add(1, 1, 0, 2'b10, 0, 0, "sat_a2");
    add(1, 0, 0, 2'b11, 1, 1, "sat_a3");
    for (int k = 2; k <= 5; k++) begin
      add(1, 1, 0, 2'b01, 0, (k - 1 > 3) ? 3 : k - 1, $sformatf("sat%0d_1", k));
      add(1, 1, 0, 2'b10, 0, (k - 1 > 3) ? 3 : k - 1, $sformatf("sat%0d_2", k));
      add(1, 0, 0, 2'b11, 1, (k > 3) ? 3 : k, $sformatf("sat%0d_3", k));
    end
    // Sixth detection with clear on the same edge: count 0 while w is high.
    add(1, 1, 0, 2'b01, 0, 3, "clr6_1");
    add(1, 1, 0, 2'b10, 0, 3, "clr6_2");
    add(1, 0, 1, 2'b11, 1, 0, "clr6_3");
    add(1, 0, 0, 2'b00, 0, 0, "clr6_4");

    foreach (tbl[i]) step(tbl[i]);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/detector_110.md
DETECTOR_110 -- requirements
Module: detector_110

Interface
REQ-001 The block SHALL expose parameter CNT_W, default 8, setting the detection-counter width; only used when DETECTOR_110_COUNT_EN is defined; legal range 1..32.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-low (asserted when 0, sampled on rising clk).
REQ-004 The block SHALL have port a  input  1  serial data bit, sampled once per rising clk edge.
REQ-005 The block SHALL have port w  output  1  detect flag; high while the FSM is in state GOT110.
REQ-006 The block SHALL have port state  output  2  current FSM state encoding, for debug.
REQ-007 With DETECTOR_110_COUNT_EN, the block SHALL add port cnt_clr  input  1  synchronous counter clear, active-high.
REQ-008 With DETECTOR_110_COUNT_EN, the block SHALL add port det_cnt  output  CNT_W  number of detections since reset or clear.

Function
REQ-009 The FSM SHALL be a Moore machine with four states: RESET=2'b00, GOT1=2'b01, GOT11=2'b10, GOT110=2'b11.
REQ-010 From RESET: a=1 -> GOT1; a=0 -> RESET.
REQ-011 From GOT1: a=1 -> GOT11; a=0 -> RESET.
REQ-012 From GOT11: a=1 -> GOT11 (any run of 1s of length >=2 stays here); a=0 -> GOT110.
REQ-013 From GOT110: a=1 -> GOT1 (overlap: the trailing 1 starts a new match); a=0 -> RESET.
REQ-014 w SHALL be decoded solely from the registered state (w = state==GOT110), glitch-free, with no combinational path from a to w.
REQ-015 Latency: w SHALL rise in the cycle following the rising edge that samples the final 0 of "110", and stay high for exactly one cycle per detection.
REQ-016 Consecutive detections SHALL be separated by at least two non-detect cycles (the minimum pattern is 1,1,0,1,1,0).
REQ-017 The state output SHALL equal the registered state register at all times.
REQ-018 With DETECTOR_110_COUNT_EN, det_cnt SHALL increment by 1 on every edge where the next state is GOT110.
REQ-019 det_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-020 cnt_clr=1 SHALL set det_cnt to 0 on the next edge; a simultaneous clear and increment SHALL yield 0.
REQ-021 cnt_clr SHALL NOT affect the FSM state or w.

Reset
REQ-022 When rst=0 at a rising clk edge, the state SHALL become RESET, w SHALL become 0 and det_cnt (if present) SHALL become 0, regardless of a and cnt_clr.
REQ-023 Reset asserted mid-pattern SHALL discard partial progress; detection resumes from RESET on the first edge with rst=1.
REQ-024 Before the first reset edge, outputs are undefined; the bench SHALL apply reset before checking.

Configuration
REQ-025 Macro DETECTOR_110_COUNT_EN SHALL compile in the cnt_clr/det_cnt ports and the saturating counter.
REQ-026 Without DETECTOR_110_COUNT_EN, those ports and the counter logic SHALL be absent; FSM behaviour SHALL be identical in both builds.

Verification
REQ-027 Hold rst=0 for 2 edges with a toggling -> state=00 and w=0 throughout; det_cnt=0.
REQ-028 a=1,1,0 on successive edges after reset -> state goes 01,10,11; w=1 for exactly the cycle after the third edge; det_cnt=1.
REQ-029 a=1,1,1,1,0,0 -> exactly one w pulse, after the fifth edge; state then 00.
REQ-030 a=1,1,0,1,1,0 -> two w pulses, three cycles apart; det_cnt=2. a=0,1,0,1,0 -> w never asserts.
REQ-031 a=1,1 then rst=0 for one edge, then a=0 -> no w pulse; state=00.
REQ-032 With CNT_W=2: five detections -> det_cnt saturates at 3. Then cnt_clr=1 on the same edge as a sixth detection -> det_cnt=0 while w=1.
